wb_cmd_master: RTL and testbench

Synthesizable Wishbone master that drains a queued command stream and executes single Wishbone classic cycles against the I2CMB register file, one command at a time. It sits directly upstream of the Wishbone port of the DUT, on the same bus signals the verification interface drives. It returns one response per command, carrying read data and error flags, and can optionally block on the DUT interrupt after a cycle. It lets an on-chip sequencer or emulation harness replace the behavioural bus driver.

---
 rtl/wb_cmd_master_pkg.sv | 32 +++
 rtl/wb_cmd_master_if.sv | 26 ++
 rtl/wb_cmd_master_fifo.sv | 55 +++++
 rtl/wb_cmd_master.sv | 168 ++++++++++++++++
 tb/tb_wb_cmd_master.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/wb_cmd_master_pkg.sv
// Shared types for the Wishbone command master: FSM states, the queued
// command record and the bit positions of the response error flags.
package wb_cmd_pkg;

    // Widths of the queued command record; the top-level bus widths default to these.
    localparam int CMD_ADDR_W = 2;
    localparam int CMD_DATA_W = 8;

    // Bit positions inside rsp_err_o.
    localparam int ERR_ACK_TO = 0;
    localparam int ERR_IRQ_TO = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        IRQ  = 2'd2,
        RESP = 2'd3
    } state_e;

    typedef struct packed {
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] data;
        logic                  we;
        logic                  wait_irq;
    } cmd_t;

    // Larger of two timeouts; sizes the shared wait counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/wb_cmd_master_if.sv
// Wishbone classic bus plus DUT interrupt, as seen from the master side.
interface wb_cmd_master_if
    import wb_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH = CMD_ADDR_W,
    parameter int DATA_WIDTH = CMD_DATA_W
);
    logic                  cyc_o;
    logic                  stb_o;
    logic                  we_o;
    logic [ADDR_WIDTH-1:0] adr_o;
    logic [DATA_WIDTH-1:0] dat_o;
    logic                  ack_i;
    logic [DATA_WIDTH-1:0] dat_i;
    logic                  irq_i;

    modport master (
        output cyc_o, stb_o, we_o, adr_o, dat_o,
        input  ack_i, dat_i, irq_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, adr_o, dat_o,
        output ack_i, dat_i, irq_i
    );
endinterface

// File: rtl/wb_cmd_master_fifo.sv
// Command FIFO: synchronous, power-of-two depth, combinational head read.
// Push is refused when full; pop is ignored when empty.
module wb_cmd_fifo
    import wb_cmd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  cmd_t                   din_i,
    input  logic                   pop_i,
    output cmd_t                   dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);

    cmd_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone command master: drains queued commands, runs one classic cycle
// each, optionally waits for the DUT interrupt, returns one response per
// command in order.
module wb_cmd_master
    import wb_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH  = CMD_ADDR_W,
    parameter int DATA_WIDTH  = CMD_DATA_W,
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 255,
    parameter int IRQ_TIMEOUT = 4095
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_data_i,
    input  logic                  cmd_we_i,
    input  logic                  cmd_wait_irq_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic [1:0]            rsp_err_o,
    output logic                  busy_o,
    wb_cmd_master_if.master       wb
);
    localparam int            CW       = $clog2(max_int(ACK_TIMEOUT, IRQ_TIMEOUT) + 1);
    localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] IRQ_LAST = CW'(IRQ_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_SAT  = '1;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic                    wait_irq_q, wait_irq_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [1:0]              rsp_err_q, rsp_err_d;

    cmd_t                    cmd_in, cmd_head;
    logic                    fifo_full, fifo_empty, fifo_pop;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                    ack_last, irq_last;

    assign cmd_in = '{addr: cmd_addr_i, data: cmd_data_i,
                      we: cmd_we_i, wait_irq: cmd_wait_irq_i};

    wb_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (cmd_valid_i),
        .din_i   (cmd_in),
        .pop_i   (fifo_pop),
        .dout_o  (cmd_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Ready depends only on occupancy; a same-cycle pop does not free a slot early.
    assign cmd_ready_o = ~fifo_full;
    assign fifo_pop    = (state_q == IDLE) & ~fifo_empty;
    assign busy_o      = (state_q != IDLE) | (fifo_count != '0);
    assign ack_last    = (cnt_q >= ACK_LAST);
    assign irq_last    = (cnt_q >= IRQ_LAST);

    assign rsp_valid_o = (state_q == RESP);
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign wb.cyc_o    = cyc_q;
    assign wb.stb_o    = stb_q;
    assign wb.we_o     = we_q;
    assign wb.adr_o    = adr_q;
    assign wb.dat_o    = dat_q;

    // State and datapath registers; async reset drops the bus immediately.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            wait_irq_q <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            wait_irq_q <= wait_irq_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Next state: ack beats a coinciding timeout, irq beats a coinciding timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (!fifo_empty) state_d = BUS;
            BUS: begin
                if (wb.ack_i)      state_d = wait_irq_q ? IRQ : RESP;
                else if (ack_last) state_d = RESP;
            end
            IRQ:  if (wb.irq_i || irq_last) state_d = RESP;
            RESP: if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: launch the cycle on pop, clear bus on ack/timeout, record results.
    always_comb begin
        cyc_d      = cyc_q;
        stb_d      = stb_q;
        we_d       = we_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        wait_irq_d = wait_irq_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        if (state_d != state_q)  cnt_d = '0;
        else if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
        else                     cnt_d = cnt_q;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    cyc_d      = 1'b1;
                    stb_d      = 1'b1;
                    we_d       = cmd_head.we;
                    adr_d      = cmd_head.addr;
                    dat_d      = cmd_head.we ? cmd_head.data : '0;
                    wait_irq_d = cmd_head.wait_irq;
                    rsp_data_d = '0;
                    rsp_err_d  = '0;
                end
            end
            BUS: begin
                if (wb.ack_i || ack_last) begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                    we_d  = 1'b0;
                    adr_d = '0;
                    dat_d = '0;
                    if (wb.ack_i) begin
                        if (!we_q) rsp_data_d = wb.dat_i;
                    end else begin
                        rsp_err_d[ERR_ACK_TO] = 1'b1;
                    end
                end
            end
            IRQ: begin
                if (!wb.irq_i && irq_last) rsp_err_d[ERR_IRQ_TO] = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: directed and random commands against a slave
// model with programmable ack/irq delays and a register-file reference.
module tb_wb_cmd_master;
    localparam int ACK_TO = 8;
    localparam int IRQ_TO = 24;
    localparam int DEPTH  = 4;

    logic       clk, rst_n;
    logic       cmd_valid, cmd_ready, cmd_we, cmd_wi;
    logic [1:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       rsp_valid, rsp_ready, busy;
    logic [7:0] rsp_data;
    logic [1:0] rsp_err;

    int n_tests = 0;
    int n_fail  = 0;

    wb_cmd_master_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) wb ();

    wb_cmd_master #(
        .ADDR_WIDTH(2), .DATA_WIDTH(8), .FIFO_DEPTH(DEPTH),
        .ACK_TIMEOUT(ACK_TO), .IRQ_TIMEOUT(IRQ_TO)
    ) dut (
        .clk_i(clk), .rst_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
        .cmd_we_i(cmd_we), .cmd_wait_irq_i(cmd_wi),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
        .busy_o(busy), .wb(wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: ack after ack_dly extra stb cycles, irq irq_dly cycles after the ack edge.
    int         ack_dly = 0, irq_dly = 1000;
    int         n = 0, m = 0;
    bit         counting = 0, ack_prev = 0;
    logic [7:0] sregs [0:3] = '{8'h00, 8'h00, 8'h00, 8'h00};

    always @(negedge clk) begin
        if (ack_prev) begin counting = 1; m = 0; end
        else if (counting) m++;
        ack_prev  = 0;
        wb.ack_i  = 1'b0;
        wb.dat_i  = 8'($urandom);
        if (wb.cyc_o && wb.stb_o) begin
            if (n == 0) counting = 0;
            n++;
            if (n == ack_dly + 1) begin
                wb.ack_i = 1'b1;
                ack_prev = 1;
                if (wb.we_o) sregs[wb.adr_o] = wb.dat_o;
                wb.dat_i = sregs[wb.adr_o];
            end
        end else begin
            n = 0;
        end
        wb.irq_i = counting && (m >= irq_dly);
    end

    // Reference register file contents, updated in command order.
    logic [7:0] mdl [0:3] = '{8'h00, 8'h00, 8'h00, 8'h00};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One command end to end; caller is at a negedge with the FSM idle.
    task automatic do_cmd(input logic [1:0] a, input logic [7:0] d, input logic we,
                          input logic wi, input int ad, input int id);
        int         pre, hi, gap, t, exp_hi, exp_gap;
        bit         ok;
        logic       ack_to, irq_to;
        logic [7:0] exp_d;
        ack_to  = (ad + 1 > ACK_TO);
        irq_to  = wi && !ack_to && (id + 1 > IRQ_TO);
        exp_hi  = ack_to ? ACK_TO : ad + 1;
        exp_gap = (wi && !ack_to) ? (irq_to ? IRQ_TO : id + 1) : 0;
        exp_d   = (!we && !ack_to) ? mdl[a] : 8'h00;
        if (we && !ack_to) mdl[a] = d;

        ack_dly = ad; irq_dly = id;
        cmd_valid = 1; cmd_addr = a; cmd_data = d; cmd_we = we; cmd_wi = wi;
        chk("cmd_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 0;
        pre = 0; hi = 0; gap = 0; t = 0; ok = 1;
        while (!wb.cyc_o && t < 20) begin pre++; t++; @(negedge clk); end
        while (wb.cyc_o && t < 100) begin
            if (wb.adr_o !== a || wb.we_o !== we || !wb.stb_o ||
                wb.dat_o !== (we ? d : 8'h00)) ok = 0;
            hi++; t++; @(negedge clk);
        end
        while (!rsp_valid && t < 200) begin gap++; t++; @(negedge clk); end
        chk("start_latency", pre, 1);
        chk("cyc_length", hi, exp_hi);
        chk("bus_fields", ok, 1);
        chk("rsp_gap", gap, exp_gap);
        chk("rsp_data", rsp_data, exp_d);
        chk("rsp_err", rsp_err, {irq_to, ack_to});
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        chk("rsp_drop", rsp_valid, 0);
        chk("busy_idle", busy, 0);
    endtask

    logic [7:0] exp_dq[$];
    logic [1:0] exp_eq[$];

    initial begin
        int         k, got, t;
        logic       bwe;
        logic [1:0] ba;
        logic [7:0] bd, d0;
        logic [1:0] e0;
        bit         seen_rsp, seen_cyc;

        rst_n = 0; cmd_valid = 0; rsp_ready = 0;
        cmd_addr = 0; cmd_data = 0; cmd_we = 0; cmd_wi = 0;
        repeat (2) @(negedge clk);
        chk("rst_cyc", wb.cyc_o, 0);
        chk("rst_stb", wb.stb_o, 0);
        chk("rst_we", wb.we_o, 0);
        chk("rst_adr", wb.adr_o, 0);
        chk("rst_dat", wb.dat_o, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        rst_n = 1;
        @(negedge clk);

        // Directed: write with 2-cycle ack, reads, ack timeout, irq wait and irq timeout.
        do_cmd(2'd3, 8'hC0, 1, 0, 2, 1000);
        do_cmd(2'd0, 8'h80, 1, 0, 0, 1000);
        do_cmd(2'd0, 8'h5A, 0, 0, 1, 1000);
        do_cmd(2'd3, 8'h00, 0, 0, 3, 1000);
        do_cmd(2'd1, 8'h55, 1, 0, 1000, 1000);
        do_cmd(2'd1, 8'h00, 0, 0, 1000, 1000);
        do_cmd(2'd2, 8'hA7, 1, 0, ACK_TO - 1, 1000);
        do_cmd(2'd2, 8'hAA, 1, 1, 0, 19);
        do_cmd(2'd2, 8'hAB, 1, 1, 1, 1000);
        do_cmd(2'd2, 8'h00, 0, 1, 0, 0);
        do_cmd(2'd1, 8'h3C, 1, 1, 2, IRQ_TO - 1);
        do_cmd(2'd1, 8'h00, 0, 1, 1000, 0);

        // Random single commands.
        for (int i = 0; i < 24; i++)
            do_cmd(2'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 10)), int'($urandom_range(0, 30)));

        // Burst with response stalled: one in flight plus a full FIFO accepted.
        ack_dly = int'($urandom_range(0, 3)); irq_dly = 1000; cmd_wi = 0;
        k = 0;
        repeat (14) begin
            @(negedge clk);
            if (k < 6 && cmd_ready) begin
                ba = 2'($urandom); bd = 8'($urandom); bwe = 1'($urandom);
                cmd_valid = 1; cmd_addr = ba; cmd_data = bd; cmd_we = bwe;
                exp_dq.push_back(bwe ? 8'h00 : mdl[ba]);
                exp_eq.push_back(2'b00);
                if (bwe) mdl[ba] = bd;
                k++;
            end else begin
                cmd_valid = 0;
            end
        end
        cmd_valid = 0;
        chk("burst_accepts", k, DEPTH + 1);
        chk("burst_full_ready", cmd_ready, 0);
        chk("burst_busy", busy, 1);
        chk("hold_valid0", rsp_valid, 1);
        d0 = rsp_data; e0 = rsp_err;
        repeat (4) @(negedge clk);
        chk("hold_valid1", rsp_valid, 1);
        chk("hold_data", rsp_data, d0);
        chk("hold_err", rsp_err, e0);
        rsp_ready = 1;
        got = 0; t = 0;
        while (got < DEPTH + 1 && t < 300) begin
            if (rsp_valid) begin
                chk("burst_data", rsp_data, exp_dq.pop_front());
                chk("burst_err", rsp_err, exp_eq.pop_front());
                got++;
            end
            t++;
            @(negedge clk);
        end
        rsp_ready = 0;
        chk("burst_count", got, DEPTH + 1);
        repeat (2) @(negedge clk);
        chk("burst_busy_end", busy, 0);

        // Reset in the middle of a bus cycle with more commands queued.
        ack_dly = 1000;
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1; cmd_addr = 2'(i); cmd_data = 8'(i); cmd_we = 1;
            @(negedge clk);
        end
        cmd_valid = 0;
        t = 0;
        while (!wb.cyc_o && t < 10) begin t++; @(negedge clk); end
        chk("pre_rst_cyc", wb.cyc_o, 1);
        chk("pre_rst_busy", busy, 1);
        #2 rst_n = 0;
        #1;
        chk("async_rst_cyc", wb.cyc_o, 0);
        chk("async_rst_stb", wb.stb_o, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_ready", cmd_ready, 1);
        @(negedge clk);
        rst_n = 1;
        rsp_ready = 1;
        seen_rsp = 0; seen_cyc = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid) seen_rsp = 1;
            if (wb.cyc_o) seen_cyc = 1;
        end
        chk("post_rst_no_rsp", seen_rsp, 0);
        chk("post_rst_no_cyc", seen_cyc, 0);
        chk("post_rst_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
